syn_mulberry_xbar: RTL
======================

# syn_mulberry_xbar

Parametrised Mulberry bus crossbar for the GPU subsystem. It is the next generation of the fixed two-master / three-slave Mulberry arrangement. It connects P_NUM_MASTERS requesters (GPU line buffer, GPU core, …) to P_NUM_SLAVES compute slaves (random, multiplier, divider, …) with round-robin arbitration on both the request path and the response path. Responses are routed back to masters by master ID. It sits between the GPU job engines and the arithmetic slaves, replacing point-to-point muxing.

## Interface
Parameters:
- P_NUM_MASTERS, 2, number of masters; master i uses MID i+1, and MID 0 means idle
- P_NUM_SLAVES, 3, number of slaves; slave j is addressed by SID j+1, and SID 0 means idle
- P_DATA_W, 32, request/response payload width
- P_MID_W, $clog2(P_NUM_MASTERS+1), MID field width
- P_SID_W, $clog2(P_NUM_SLAVES+1), SID field width

Ports:
- clk_ir  in  1  clock
- rst_ih  in  1  reset, asynchronous, active-high
- mstr_req_i  in  P_NUM_MASTERS  per-master request; held until granted
- mstr_sid_i  in  P_NUM_MASTERS*P_SID_W  per-master target SID
- mstr_data_i  in  P_NUM_MASTERS*P_DATA_W  per-master request payload
- mstr_gnt_o  out  P_NUM_MASTERS  one-hot, one-cycle grant (combinational)
- mstr_rsp_valid_o  out  P_NUM_MASTERS  one-hot registered response strobe
- mstr_rsp_data_o  out  P_DATA_W  response payload, shared by all masters
- slv_req_o  out  P_NUM_SLAVES  one-hot registered request strobe
- slv_mid_o  out  P_MID_W  MID of the requesting master, shared
- slv_data_o  out  P_DATA_W  request payload, shared
- slv_rdy_i  in  P_NUM_SLAVES  slave can accept a request in the next cycle
- slv_rsp_valid_i  in  P_NUM_SLAVES  response pending; held until acked
- slv_rsp_mid_i  in  P_NUM_SLAVES*P_MID_W  per-slave response destination MID
- slv_rsp_data_i  in  P_NUM_SLAVES*P_DATA_W  per-slave response payload
- slv_rsp_ack_o  out  P_NUM_SLAVES  one-hot response accept (combinational)
- err_cnt_o  out  16  illegal-ID counter; present only with SYN_MULBERRY_ERR_CNT_EN

## Operation
Request path:
- Master i is eligible when mstr_req_i[i] is high and either its SID is legal and slv_rdy_i[SID-1] is high, or its SID is illegal (0 or greater than P_NUM_SLAVES).
- Each cycle, at most one eligible master is granted. Search is round-robin starting at req_ptr. After a grant, req_ptr becomes the granted index + 1, modulo P_NUM_MASTERS.
- A master stalled on a busy slave never blocks eligible masters.
- Legal grant: slv_req_o[SID-1], slv_mid_o = i+1 and slv_data_o are registered for exactly one cycle.
- Illegal-SID grant: the request is consumed, no slv_req_o is raised, and an error event is generated.

Response path:
- Each cycle, one pending slave is acked. Search is round-robin from rsp_ptr, which then advances past the acked index.
- Acked with legal MID: mstr_rsp_valid_o[MID-1] and mstr_rsp_data_o are registered for one cycle.
- MID 0 or MID greater than P_NUM_MASTERS: acked, dropped, error event.

General:
- The request and response paths are fully independent and may both fire in the same cycle.
- When idle, slv_mid_o, slv_data_o and mstr_rsp_data_o hold their last values.

## Timing
- Reset (asynchronous): slv_req_o, mstr_rsp_valid_o, slv_mid_o, slv_data_o and mstr_rsp_data_o are cleared to 0, req_ptr and rsp_ptr to 0, err_cnt_o to 0. Any in-flight strobe is discarded.
- Request latency: grant in cycle N, slv_req_o in cycle N+1.
- Throughput: one request per cycle; back-to-back requests to the same slave are allowed while slv_rdy_i stays high.
- Response latency: ack in cycle N, mstr_rsp_valid_o in cycle N+1. Throughput is one response per cycle.
- slv_rdy_i is sampled in the grant cycle. A high slv_rdy_i commits the slave to accept the strobe in the following cycle.
- Two slaves returning responses to the same master in consecutive cycles produce consecutive mstr_rsp_valid_o pulses. Masters must accept every cycle.

## Configuration
- SYN_MULBERRY_ERR_CNT_EN defined:
  - err_cnt_o is present.
  - It increments by 1 per illegal-SID grant and by 1 per illegal-MID ack, so a simultaneous request error and response error add 2.
  - It saturates at 16'hFFFF.
- SYN_MULBERRY_ERR_CNT_EN undefined:
  - The port and counter are absent.
  - Illegal transactions are still consumed and dropped silently.

## Test plan
- Reset and idle: rst_ih pulse mid-transfer. Expect every output 0 in the same cycle, and no strobe after reset release.
- Round-robin fairness: masters 0 and 1 request continuously to SID 2, with slv_rdy_i all high. Expect grants alternating 0,1,0,1 and slv_req_o[1] high every cycle, with slv_mid_o alternating 1,2.
- Busy slave bypass: master 0 targets SID 3 with slv_rdy_i[2]=0, and master 1 targets SID 1. Expect master 1 granted in consecutive cycles and master 0 granted in the first cycle after slv_rdy_i[2] rises.
- Response routing: slaves 0 and 2 both raise rsp_valid in the same cycle with MID 2 and data 32'hA5A5_0001 / 32'h5A5A_0002. Expect acks in two consecutive cycles and mstr_rsp_valid_o[1] pulses at N+1 and N+2 carrying both data words in round-robin order.
- Illegal IDs (macro on): master 0 sends SID 0, while slave 1 simultaneously returns MID 3 with P_NUM_MASTERS=2. Expect both consumed, no strobes, and err_cnt_o increasing from 0 to 2 in one cycle.
- Parameter sweep: P_NUM_MASTERS=4, P_NUM_SLAVES=5 with random traffic. Expect a scoreboard match of every request to exactly one slave strobe and every response to exactly one master strobe.

Source files
------------

// File: rtl/syn_mulberry_xbar_if.sv
// Mulberry crossbar bus bundle: master-side request/response and slave-side request/response.
// The crossbar binds the slave modport; the surrounding job engines/slaves bind master.
interface syn_mulberry_xbar_if #(
  parameter int unsigned P_NUM_MASTERS = 2,
  parameter int unsigned P_NUM_SLAVES  = 3,
  parameter int unsigned P_DATA_W      = 32,
  parameter int unsigned P_MID_W       = $clog2(P_NUM_MASTERS + 1),
  parameter int unsigned P_SID_W       = $clog2(P_NUM_SLAVES + 1)
);
  logic [P_NUM_MASTERS-1:0]          mstr_req_i;
  logic [P_NUM_MASTERS*P_SID_W-1:0]  mstr_sid_i;
  logic [P_NUM_MASTERS*P_DATA_W-1:0] mstr_data_i;
  logic [P_NUM_MASTERS-1:0]          mstr_gnt_o;
  logic [P_NUM_MASTERS-1:0]          mstr_rsp_valid_o;
  logic [P_DATA_W-1:0]               mstr_rsp_data_o;
  logic [P_NUM_SLAVES-1:0]           slv_req_o;
  logic [P_MID_W-1:0]                slv_mid_o;
  logic [P_DATA_W-1:0]               slv_data_o;
  logic [P_NUM_SLAVES-1:0]           slv_rdy_i;
  logic [P_NUM_SLAVES-1:0]           slv_rsp_valid_i;
  logic [P_NUM_SLAVES*P_MID_W-1:0]   slv_rsp_mid_i;
  logic [P_NUM_SLAVES*P_DATA_W-1:0]  slv_rsp_data_i;
  logic [P_NUM_SLAVES-1:0]           slv_rsp_ack_o;

  modport slave (
    input  mstr_req_i, mstr_sid_i, mstr_data_i, slv_rdy_i,
    input  slv_rsp_valid_i, slv_rsp_mid_i, slv_rsp_data_i,
    output mstr_gnt_o, mstr_rsp_valid_o, mstr_rsp_data_o,
    output slv_req_o, slv_mid_o, slv_data_o, slv_rsp_ack_o
  );

  modport master (
    output mstr_req_i, mstr_sid_i, mstr_data_i, slv_rdy_i,
    output slv_rsp_valid_i, slv_rsp_mid_i, slv_rsp_data_i,
    input  mstr_gnt_o, mstr_rsp_valid_o, mstr_rsp_data_o,
    input  slv_req_o, slv_mid_o, slv_data_o, slv_rsp_ack_o
  );
endinterface

// File: rtl/syn_mulberry_xbar.sv
// Mulberry crossbar: round-robin request and response arbitration, responses routed by MID.
// Optional illegal-ID counter err_cnt_o enabled by defining SYN_MULBERRY_ERR_CNT_EN.
module syn_mulberry_xbar #(
  parameter int unsigned P_NUM_MASTERS = 2,
  parameter int unsigned P_NUM_SLAVES  = 3,
  parameter int unsigned P_DATA_W      = 32,
  parameter int unsigned P_MID_W       = $clog2(P_NUM_MASTERS + 1),
  parameter int unsigned P_SID_W       = $clog2(P_NUM_SLAVES + 1)
) (
  input logic clk_ir,
  input logic rst_ih,
`ifdef SYN_MULBERRY_ERR_CNT_EN
  output logic [15:0] err_cnt_o,
`endif
  syn_mulberry_xbar_if.slave bus
);
  localparam int unsigned MPtrW = (P_NUM_MASTERS > 1) ? $clog2(P_NUM_MASTERS) : 1;
  localparam int unsigned SPtrW = (P_NUM_SLAVES > 1) ? $clog2(P_NUM_SLAVES) : 1;

  logic [P_SID_W-1:0]       mstr_sid  [P_NUM_MASTERS];
  logic [P_DATA_W-1:0]      mstr_data [P_NUM_MASTERS];
  logic [P_NUM_SLAVES-1:0]  sid_dec   [P_NUM_MASTERS];
  logic [P_MID_W-1:0]       rsp_mid   [P_NUM_SLAVES];
  logic [P_DATA_W-1:0]      rsp_data  [P_NUM_SLAVES];
  logic [P_NUM_MASTERS-1:0] mid_dec   [P_NUM_SLAVES];
  logic [P_NUM_MASTERS-1:0] mstr_elig;

  logic                     gnt_found, ack_found, gnt_illegal;
  logic [MPtrW-1:0]         gnt_idx, req_ptr_q, req_ptr_nxt;
  logic [SPtrW-1:0]         ack_idx, rsp_ptr_q, rsp_ptr_nxt;
  logic [P_NUM_MASTERS-1:0] gnt;
  logic [P_NUM_SLAVES-1:0]  ack;

  logic [P_NUM_SLAVES-1:0]  slv_req_q;
  logic [P_MID_W-1:0]       slv_mid_q;
  logic [P_DATA_W-1:0]      slv_data_q;
  logic [P_NUM_MASTERS-1:0] rsp_valid_q;
  logic [P_DATA_W-1:0]      rsp_data_q;

  // Decoded IDs are one-hot for legal values and all-zero for 0 or out-of-range IDs.
  always_comb begin
    for (int i = 0; i < P_NUM_MASTERS; i++) begin
      mstr_sid[i]  = bus.mstr_sid_i[i*P_SID_W +: P_SID_W];
      mstr_data[i] = bus.mstr_data_i[i*P_DATA_W +: P_DATA_W];
    end
    for (int j = 0; j < P_NUM_SLAVES; j++) begin
      rsp_mid[j]  = bus.slv_rsp_mid_i[j*P_MID_W +: P_MID_W];
      rsp_data[j] = bus.slv_rsp_data_i[j*P_DATA_W +: P_DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < P_NUM_MASTERS; i++) begin
      for (int j = 0; j < P_NUM_SLAVES; j++) begin
        sid_dec[i][j] = (mstr_sid[i] == P_SID_W'(j + 1));
      end
    end
    for (int j = 0; j < P_NUM_SLAVES; j++) begin
      for (int i = 0; i < P_NUM_MASTERS; i++) begin
        mid_dec[j][i] = (rsp_mid[j] == P_MID_W'(i + 1));
      end
    end
  end

  // Illegal SIDs are always eligible so they get consumed rather than wedging the master.
  always_comb begin
    for (int i = 0; i < P_NUM_MASTERS; i++) begin
      mstr_elig[i] = bus.mstr_req_i[i] &&
                     ((sid_dec[i] == '0) || ((sid_dec[i] & bus.slv_rdy_i) != '0));
    end
  end

  always_comb begin
    logic [MPtrW-1:0] cidx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cidx      = '0;
    for (int unsigned k = 0; k < P_NUM_MASTERS; k++) begin
      cidx = (32'(req_ptr_q) + k >= P_NUM_MASTERS) ?
             MPtrW'(32'(req_ptr_q) + k - P_NUM_MASTERS) : MPtrW'(32'(req_ptr_q) + k);
      if (!gnt_found && mstr_elig[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
    if (rst_ih) gnt_found = 1'b0;
    gnt = '0;
    if (gnt_found) gnt[gnt_idx] = 1'b1;
    gnt_illegal = (sid_dec[gnt_idx] == '0);
    req_ptr_nxt = (gnt_idx == MPtrW'(P_NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    logic [SPtrW-1:0] cidx;
    ack_found = 1'b0;
    ack_idx   = '0;
    cidx      = '0;
    for (int unsigned k = 0; k < P_NUM_SLAVES; k++) begin
      cidx = (32'(rsp_ptr_q) + k >= P_NUM_SLAVES) ?
             SPtrW'(32'(rsp_ptr_q) + k - P_NUM_SLAVES) : SPtrW'(32'(rsp_ptr_q) + k);
      if (!ack_found && bus.slv_rsp_valid_i[cidx]) begin
        ack_found = 1'b1;
        ack_idx   = cidx;
      end
    end
    if (rst_ih) ack_found = 1'b0;
    ack = '0;
    if (ack_found) ack[ack_idx] = 1'b1;
    rsp_ptr_nxt = (ack_idx == SPtrW'(P_NUM_SLAVES - 1)) ? '0 : ack_idx + 1'b1;
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      req_ptr_q   <= '0;
      rsp_ptr_q   <= '0;
      slv_req_q   <= '0;
      slv_mid_q   <= '0;
      slv_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      slv_req_q   <= gnt_found ? sid_dec[gnt_idx] : '0;
      rsp_valid_q <= ack_found ? mid_dec[ack_idx] : '0;
      if (gnt_found) begin
        req_ptr_q <= req_ptr_nxt;
        if (!gnt_illegal) begin
          slv_mid_q  <= P_MID_W'(gnt_idx) + P_MID_W'(1);
          slv_data_q <= mstr_data[gnt_idx];
        end
      end
      if (ack_found) begin
        rsp_ptr_q <= rsp_ptr_nxt;
        if (mid_dec[ack_idx] != '0) rsp_data_q <= rsp_data[ack_idx];
      end
    end
  end

`ifdef SYN_MULBERRY_ERR_CNT_EN
  logic        ack_err, gnt_err;
  logic [16:0] err_sum;
  logic [15:0] err_cnt_q;

  // A request error and a response error in the same cycle count as two.
  always_comb begin
    gnt_err = gnt_found && gnt_illegal;
    ack_err = ack_found && (mid_dec[ack_idx] == '0);
    err_sum = {1'b0, err_cnt_q} + 17'(gnt_err) + 17'(ack_err);
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) err_cnt_q <= '0;
    else        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign bus.mstr_gnt_o       = gnt;
  assign bus.slv_rsp_ack_o    = ack;
  assign bus.slv_req_o        = slv_req_q;
  assign bus.slv_mid_o        = slv_mid_q;
  assign bus.slv_data_o       = slv_data_q;
  assign bus.mstr_rsp_valid_o = rsp_valid_q;
  assign bus.mstr_rsp_data_o  = rsp_data_q;
endmodule
